// File: rtl/conv_unit_output_collector.sv
`default_nettype none
// ============================================================================
// Module   : conv_unit_output_collector
// Purpose  : Per-lane FIFOs for conv_unit results, drained round-robin onto
//            one AXI-Stream master; raises a stall request when FIFOs fill.
// Revision : 1.0 - initial release
// ============================================================================
module conv_unit_output_collector #(
    parameter int DATA_WIDTH       = 16,
    parameter int KERNEL_W_MAX     = 3,
    parameter int TUSER_WIDTH      = 4,
    parameter int INDEX_IS_1x1     = 0,
    parameter int INDEX_BLOCK_LAST = 3,
    parameter int FIFO_DEPTH       = 4,
    parameter int STALL_SLACK      = 2
) (
    input  logic                                     aclk,
    input  logic                                     aresetn,
    input  logic                                     aclken,
    input  logic [KERNEL_W_MAX-1:0]                  s_valid,
    input  logic [KERNEL_W_MAX-1:0][DATA_WIDTH-1:0]  s_data,
    input  logic [KERNEL_W_MAX-1:0]                  s_last,
    input  logic [KERNEL_W_MAX-1:0][TUSER_WIDTH-1:0] s_user,
    output logic                                     s_clken_req,
    output logic                                     m_valid,
    input  logic                                     m_ready,
    output logic [DATA_WIDTH-1:0]                    m_data,
    output logic                                     m_last,
    output logic [TUSER_WIDTH-1:0]                   m_user,
    output logic [$clog2(KERNEL_W_MAX)-1:0]          m_lane,
    output logic                                     overflow
);

    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam int c_cw = c_aw + 1;
    localparam int c_lw = $clog2(KERNEL_W_MAX);
    localparam int c_ew = DATA_WIDTH + TUSER_WIDTH;
    localparam logic [c_cw-1:0] c_full    = c_cw'(FIFO_DEPTH);
    localparam logic [c_cw-1:0] c_req_max = c_cw'(FIFO_DEPTH - STALL_SLACK);

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
        (STALL_SLACK < 1) || (STALL_SLACK >= FIFO_DEPTH) ||
        (INDEX_IS_1x1 >= TUSER_WIDTH) || (INDEX_BLOCK_LAST >= TUSER_WIDTH)) begin : g_param_check
        $error("conv_unit_output_collector: illegal parameter combination");
    end

    logic [c_ew-1:0]         r_mem    [KERNEL_W_MAX][FIFO_DEPTH];
    logic [c_aw-1:0]         r_wr_ptr [KERNEL_W_MAX];
    logic [c_aw-1:0]         r_rd_ptr [KERNEL_W_MAX];
    logic [c_cw-1:0]         r_count  [KERNEL_W_MAX];
    logic [c_lw-1:0]         r_rr;
    logic                    r_overflow;
    logic                    r_m_valid;
    logic [DATA_WIDTH-1:0]   r_m_data;
    logic [TUSER_WIDTH-1:0]  r_m_user;
    logic [c_lw-1:0]         r_m_lane;

    logic [KERNEL_W_MAX-1:0]   w_push_req;
    logic [KERNEL_W_MAX-1:0]   w_push_ok;
    logic [KERNEL_W_MAX-1:0]   w_drop;
    logic [KERNEL_W_MAX-1:0]   w_pop;
    logic [KERNEL_W_MAX-1:0]   w_nonempty;
    logic [2*KERNEL_W_MAX-1:0] w_dbl;
    logic [KERNEL_W_MAX-1:0]   w_rot;
    logic                      w_load_en;
    logic                      w_found;
    logic [c_lw-1:0]           w_sel;
    logic [c_ew-1:0]           w_head;
    logic                      w_clken_ok;

    assign w_load_en = !r_m_valid || m_ready;

    always_comb begin
        w_clken_ok = 1'b1;
        for (int k = 0; k < KERNEL_W_MAX; k++) begin
            w_push_req[k] = s_valid[k] & s_last[k] & aclken;
            w_nonempty[k] = (r_count[k] != '0);
            w_pop[k]      = w_load_en & w_found & (w_sel == c_lw'(k));
            // A pop on the same lane frees the slot, so a full FIFO still accepts.
            w_push_ok[k]  = w_push_req[k] & ((r_count[k] != c_full) | w_pop[k]);
            w_drop[k]     = w_push_req[k] & ~w_push_ok[k];
            if (r_count[k] > c_req_max) begin
                w_clken_ok = 1'b0;
            end
        end
    end

    // Rotate so bit i is lane (rr+i) mod K; the lowest set bit wins.
    assign w_dbl = {w_nonempty, w_nonempty};
    assign w_rot = KERNEL_W_MAX'(w_dbl >> r_rr);

    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = KERNEL_W_MAX - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_found = 1'b1;
                if (r_rr >= c_lw'(KERNEL_W_MAX - i)) begin
                    w_sel = r_rr - c_lw'(KERNEL_W_MAX - i);
                end else begin
                    w_sel = r_rr + c_lw'(i);
                end
            end
        end
    end

    assign w_head = r_mem[w_sel][r_rd_ptr[w_sel]];

    always_ff @(posedge aclk) begin
        for (int k = 0; k < KERNEL_W_MAX; k++) begin
            if (w_push_ok[k]) begin
                r_mem[k][r_wr_ptr[k]] <= {s_user[k], s_data[k]};
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int k = 0; k < KERNEL_W_MAX; k++) begin
                r_wr_ptr[k] <= '0;
                r_rd_ptr[k] <= '0;
                r_count[k]  <= '0;
            end
            r_overflow <= 1'b0;
        end else begin
            for (int k = 0; k < KERNEL_W_MAX; k++) begin
                if (w_push_ok[k]) begin
                    r_wr_ptr[k] <= r_wr_ptr[k] + c_aw'(1);
                end
                if (w_pop[k]) begin
                    r_rd_ptr[k] <= r_rd_ptr[k] + c_aw'(1);
                end
                if (w_push_ok[k] && !w_pop[k]) begin
                    r_count[k] <= r_count[k] + c_cw'(1);
                end else if (!w_push_ok[k] && w_pop[k]) begin
                    r_count[k] <= r_count[k] - c_cw'(1);
                end
            end
            if (|w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_user  <= '0;
            r_m_lane  <= '0;
            r_rr      <= '0;
        end else if (w_load_en) begin
            if (w_found) begin
                r_m_valid <= 1'b1;
                r_m_user  <= w_head[c_ew-1:DATA_WIDTH];
                r_m_data  <= w_head[DATA_WIDTH-1:0];
                r_m_lane  <= w_sel;
                if (w_sel == c_lw'(KERNEL_W_MAX - 1)) begin
                    r_rr <= '0;
                end else begin
                    r_rr <= w_sel + c_lw'(1);
                end
            end else begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign s_clken_req = w_clken_ok;
    assign m_valid     = r_m_valid;
    assign m_data      = r_m_data;
    assign m_user      = r_m_user;
    assign m_last      = r_m_user[INDEX_BLOCK_LAST];
    assign m_lane      = r_m_lane;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire
